out_demux_ms: RTL and testbench
===============================

OUT_DEMUX_MS -- requirements
Module: out_demux_ms

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning per-flow FIFO depth in words (power of two, >=2).
REQ-002 SHALL have parameter FLUX, default 4, meaning number of flows (power of two, 2..4).
REQ-003 SHALL have parameter TW, default 2, meaning tag width, equal to log2(FLUX).
REQ-004 SHALL have these ports:
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_din  in  TW+8  tagged pel, {tag, pel[7:0]}, produced by the multi-stream filter.
- in_write  in  1  in_din valid this cycle.
- in_full  out  FLUX  bit f = FIFO of flow f full; upstream SHALL NOT write tag f while set.
- cfg_din  in  TW+12  {tag, expected pel count[11:0]} for one flow block.
- cfg_write  in  1  cfg_din valid this cycle.
- out_data  out  FLUX*8  head pel of flow f at bits [8f+7:8f].
- out_valid  out  FLUX  flow f head valid.
- out_ready  in  FLUX  consumer of flow f accepts the head.
- blk_done  out  FLUX  one-cycle pulse when flow f block completes.
- err  out  FLUX  sticky protocol-error flags (see Configuration).

Function
REQ-005 SHALL route each accepted in_din pel to FIFO in_din[TW+7:8], storing pel[7:0] only.
REQ-006 SHALL accept a pel when in_write=1 and in_full[tag]=0; the pel SHALL appear on out_data/out_valid no earlier than the next cycle (no fall-through).
REQ-007 SHALL pop flow f when out_valid[f]=1 and out_ready[f]=1; the next entry SHALL be presented on the following cycle.
REQ-008 SHALL keep a per-flow occupancy count 0..DEPTH with read/write pointers wrapping modulo DEPTH.
REQ-009 in_full[f] SHALL be 1 exactly when occupancy equals DEPTH, registered; a simultaneous pop SHALL NOT unblock a push in the same cycle.
REQ-010 Simultaneous push and pop on the same non-empty, non-full flow SHALL leave occupancy unchanged.
REQ-011 out_valid[f] SHALL be 1 exactly when occupancy > 0; out_data for an empty flow SHALL hold its last value.
REQ-012 SHALL run one FSM per flow with states IDLE, RUN, DONE.
REQ-013 IDLE->RUN on cfg_write with matching tag: load the remaining counter with cfg_din[11:0]; a count of 0 SHALL go directly to DONE.
REQ-014 In RUN, every pop of flow f SHALL decrement the counter; the pop taking it to 0 SHALL move to DONE.
REQ-015 DONE SHALL assert blk_done[f] for exactly one cycle, then return to IDLE.
REQ-016 A cfg_write to a flow in RUN or DONE SHALL be ignored.
REQ-017 Pops in IDLE SHALL be allowed but not counted.
REQ-018 Flows SHALL be fully independent; any combination of one push plus FLUX pops per cycle SHALL be supported.

Reset
REQ-019 rst=1 SHALL asynchronously clear all pointers, occupancies and counters, and force every FSM to IDLE.
REQ-020 During and after reset: in_full=0, out_valid=0, out_data=0, blk_done=0, err=0.
REQ-021 Reset asserted mid-block SHALL discard all buffered pels; no blk_done SHALL be issued for the aborted block.

Configuration
REQ-022 With OUT_DEMUX_ERR_EN defined, err[f] SHALL set on a write to full flow f or a cfg_write to flow f in RUN, and hold until rst.
REQ-023 Without OUT_DEMUX_ERR_EN, err SHALL be constant 0 and those events SHALL be silently dropped or ignored.
REQ-024 Datapath behaviour SHALL be identical with and without OUT_DEMUX_ERR_EN; the offending pel is never stored.

Verification
REQ-025 Scenario: cfg tag0 count 4; write tag0 pels 0x11,0x22,0x33,0x44 with out_ready=1 -> pels out in order one cycle after each write; blk_done[0] pulses once after the 4th pop.
REQ-026 Scenario: DEPTH=16, out_ready[1]=0; write 16 tag1 pels -> in_full[1]=1 after the 16th; a 17th write (macro on) -> err[1]=1 and occupancy stays 16.
REQ-027 Scenario: round-robin 4 flows, 23 pels each, per-flow out_ready toggling randomly -> each flow's output matches its input sequence; no cross-flow mixing.
REQ-028 Scenario: flow2 full, simultaneous pop and write -> pop occurs, write blocked; next cycle in_full[2]=0.
REQ-029 Scenario: cfg tag3 count 0 -> blk_done[3] pulses within 2 cycles; cfg tag3 count 5 during RUN -> ignored; err[3]=1 with macro on, 0 without.
REQ-030 Scenario: assert rst with 7 pels buffered in flow0 in RUN -> out_valid=0, in_full=0 immediately; no blk_done after release.

Source files
------------

// File: rtl/out_demux_ms.sv
// ----------------------------------------------------------------------------
// out_demux_ms
// Splits a tagged pel stream into FLUX independent per-flow FIFOs. Each flow
// also runs a small block tracker: a configured pel count is decremented on
// every pop, and blk_done pulses for one cycle when the block is complete.
//
// Optional feature macro: OUT_DEMUX_ERR_EN
//   defined   -> err[f] sticks on a write to a full flow or a cfg_write to a
//                flow whose block is still running; cleared only by rst.
//   undefined -> err is constant 0. The offending write/cfg is dropped the
//                same way in both builds.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   in_din     in   {tag[TW-1:0], pel[7:0]}
//   in_write   in   in_din valid
//   in_full    out  per-flow FIFO full (registered)
//   cfg_din    in   {tag[TW-1:0], pel_count[11:0]}
//   cfg_write  in   cfg_din valid
//   out_data   out  head pel of flow f at [8f+7:8f]
//   out_valid  out  per-flow head valid
//   out_ready  in   per-flow consumer accept
//   blk_done   out  per-flow one-cycle block-complete pulse
//   err        out  per-flow sticky protocol error
//
// Per-flow FSM
//   state   | meaning
//   IDLE    | no block armed; pops pass through uncounted
//   RUN     | block armed; each pop decrements the remaining count
//   DONE    | block complete; blk_done high for this one cycle
// ----------------------------------------------------------------------------
module out_demux_ms #(
    parameter int DEPTH = 16,
    parameter int FLUX  = 4,
    parameter int TW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TW+7:0]       in_din,
    input  logic                in_write,
    output logic [FLUX-1:0]     in_full,
    input  logic [TW+11:0]      cfg_din,
    input  logic                cfg_write,
    output logic [FLUX*8-1:0]   out_data,
    output logic [FLUX-1:0]     out_valid,
    input  logic [FLUX-1:0]     out_ready,
    output logic [FLUX-1:0]     blk_done,
    output logic [FLUX-1:0]     err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    for (genvar f = 0; f < FLUX; f++) begin : g_flow
        logic            tag_hit;
        logic            cfg_hit;
        logic            push;
        logic            pop;
        logic            valid;
        logic [AW-1:0]   wr_ptr_q;
        logic [AW-1:0]   rd_ptr_q;
        logic [AW:0]     occ_q;
        logic [AW:0]     occ_d;
        logic            full_q;
        logic [7:0]      last_q;
        logic [7:0]      mem_q [DEPTH];
        state_t          state_q;
        state_t          state_d;
        logic [11:0]     cnt_q;
        logic [11:0]     cnt_d;

        assign tag_hit = in_write && (in_din[TW+7:8] == TW'(f));
        assign cfg_hit = cfg_write && (cfg_din[TW+11:12] == TW'(f));
        // Blocking on the registered full flag means a same-cycle pop never
        // frees room for a push; the slot opens one cycle later.
        assign push    = tag_hit && !full_q;
        assign valid   = (occ_q != '0);
        assign pop     = valid && out_ready[f];

        always_comb begin
            occ_d = occ_q;
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
                full_q   <= 1'b0;
                last_q   <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                    // Remember the departing head so an emptied flow keeps
                    // showing it instead of stale storage.
                    last_q   <= mem_q[rd_ptr_q];
                end
                occ_q  <= occ_d;
                full_q <= (occ_d == (AW+1)'(DEPTH));
            end
        end

        // Storage is not reset; it is only observed while occupancy > 0.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_din[7:0];
            end
        end

        assign in_full[f]        = full_q;
        assign out_valid[f]      = valid;
        assign out_data[8*f +: 8] = valid ? mem_q[rd_ptr_q] : last_q;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_hit) begin
                        if (cfg_din[11:0] == 12'd0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                            cnt_d   = cfg_din[11:0];
                        end
                    end
                end
                ST_RUN: begin
                    if (pop) begin
                        cnt_d = cnt_q - 12'd1;
                        if (cnt_q == 12'd1) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        assign blk_done[f] = (state_q == ST_DONE);

`ifdef OUT_DEMUX_ERR_EN
        logic err_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if ((tag_hit && full_q) || (cfg_hit && (state_q == ST_RUN))) begin
                err_q <= 1'b1;
            end
        end

        assign err[f] = err_q;
`else
        assign err[f] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_out_demux_ms.sv
module tb_out_demux_ms;

    localparam int DEPTH = 16;
    localparam int FLUX  = 4;
    localparam int TW    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [TW+7:0]       in_din;
    logic                in_write;
    logic [FLUX-1:0]     in_full;
    logic [TW+11:0]      cfg_din;
    logic                cfg_write;
    logic [FLUX*8-1:0]   out_data;
    logic [FLUX-1:0]     out_valid;
    logic [FLUX-1:0]     out_ready;
    logic [FLUX-1:0]     blk_done;
    logic [FLUX-1:0]     err;

    always #5 clk = ~clk;

    out_demux_ms #(.DEPTH(DEPTH), .FLUX(FLUX), .TW(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_din    (in_din),
        .in_write  (in_write),
        .in_full   (in_full),
        .cfg_din   (cfg_din),
        .cfg_write (cfg_write),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_done  (blk_done),
        .err       (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-flow FIFO contents as a queue, last departed pel,
    // block tracker (0 idle, 1 counting, 2 pulse due) and sticky error.
    logic [7:0] exp_q [FLUX][$];
    logic [7:0] last_pel [FLUX];
    int         mstate [FLUX];
    int         rem [FLUX];
    int         done_cnt [FLUX];
    bit         exp_err [FLUX];
    bit         wr_pend;
    int         wr_tag;
    bit         err_on;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < FLUX; f++) begin
            exp_q[f].delete();
            last_pel[f] = 8'h00;
            mstate[f]   = 0;
            rem[f]      = 0;
            exp_err[f]  = 1'b0;
        end
        wr_pend = 1'b0;
    endtask

    // Monitor: checks every flow each cycle on the falling edge.
    always @(negedge clk) begin : monitor
        int committed;
        bit pop;
        bit hit_cfg;
        if (rst === 1'b0) begin
            for (int f = 0; f < FLUX; f++) begin
                committed = exp_q[f].size() - ((wr_pend && wr_tag == f) ? 1 : 0);
                pop = (committed > 0) && out_ready[f];
                chk($sformatf("out_valid[%0d]", f), int'(out_valid[f]), int'(committed > 0));
                chk($sformatf("in_full[%0d]", f), int'(in_full[f]), int'(committed == DEPTH));
                chk($sformatf("blk_done[%0d]", f), int'(blk_done[f]), int'(mstate[f] == 2));
                chk($sformatf("err[%0d]", f), int'(err[f]), int'(exp_err[f]));
                if (committed > 0) begin
                    chk($sformatf("head[%0d]", f), int'(out_data[8*f +: 8]), int'(exp_q[f][0]));
                end else begin
                    chk($sformatf("hold[%0d]", f), int'(out_data[8*f +: 8]), int'(last_pel[f]));
                end
                if (pop) begin
                    last_pel[f] = exp_q[f].pop_front();
                end
                if (blk_done[f]) begin
                    done_cnt[f]++;
                end
                hit_cfg = cfg_write && (int'(cfg_din[TW+11:12]) == f);
                if (err_on && in_write && int'(in_din[TW+7:8]) == f && committed == DEPTH) begin
                    exp_err[f] = 1'b1;
                end
                case (mstate[f])
                    0: begin
                        if (hit_cfg) begin
                            if (cfg_din[11:0] == 12'd0) begin
                                mstate[f] = 2;
                            end else begin
                                mstate[f] = 1;
                                rem[f]    = int'(cfg_din[11:0]);
                            end
                        end
                    end
                    1: begin
                        if (hit_cfg && err_on) begin
                            exp_err[f] = 1'b1;
                        end
                        if (pop) begin
                            rem[f]--;
                            if (rem[f] == 0) begin
                                mstate[f] = 2;
                            end
                        end
                    end
                    default: mstate[f] = 0;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        in_write  = 1'b0;
        cfg_write = 1'b0;
        wr_pend   = 1'b0;
    endtask

    task automatic issue_write(input int tag, input logic [7:0] pel);
        in_din   = {TW'(tag), pel};
        in_write = 1'b1;
        if (exp_q[tag].size() < DEPTH) begin
            exp_q[tag].push_back(pel);
            wr_pend = 1'b1;
            wr_tag  = tag;
        end
    endtask

    task automatic issue_cfg(input int tag, input int count);
        cfg_din   = {TW'(tag), 12'(count)};
        cfg_write = 1'b1;
    endtask

    task automatic push_pel(input int tag, input logic [7:0] pel);
        int tries;
        tries = 0;
        while (1) begin
            tick();
            out_ready = 4'($urandom_range(0, 15));
            if (exp_q[tag].size() < DEPTH) begin
                issue_write(tag, pel);
                return;
            end
            tries++;
            if (tries > 200) begin
                chk("push_timeout", tries, 0);
                return;
            end
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base [FLUX];
`ifdef OUT_DEMUX_ERR_EN
        err_on = 1'b1;
`else
        err_on = 1'b0;
`endif
        rst       = 1'b1;
        in_din    = '0;
        in_write  = 1'b0;
        cfg_din   = '0;
        cfg_write = 1'b0;
        out_ready = '0;
        model_clear();
        for (int f = 0; f < FLUX; f++) done_cnt[f] = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_full", int'(in_full), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_blk_done", int'(blk_done), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        // Basic block of 4 on flow 0 with a free-running consumer.
        tick(); out_ready = '1; issue_cfg(0, 4);
        tick(); issue_write(0, 8'h11);
        tick(); issue_write(0, 8'h22);
        tick(); issue_write(0, 8'h33);
        tick(); issue_write(0, 8'h44);
        repeat (6) tick();
        chk("s1_done_cnt0", done_cnt[0], 1);

        // Fill flow 1, then overflow it.
        out_ready[1] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(); issue_write(1, 8'(8'h80 + i));
        end
        tick();
        chk("s2_full1", int'(in_full[1]), 1);
        issue_write(1, 8'hEE);
        tick(); tick();
        chk("s2_err1", int'(err[1]), int'(err_on));
        chk("s2_full1_hold", int'(in_full[1]), 1);
        out_ready[1] = 1'b1;
        repeat (DEPTH + 4) tick();

        // Flow 2 full: pop and blocked write in the same cycle.
        out_ready[2] = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tick(); issue_write(2, 8'(8'h40 + i));
        end
        tick(); out_ready[2] = 1'b1; issue_write(2, 8'h5A);
        tick(); out_ready[2] = 1'b0;
        chk("s4_full2_after_pop", int'(in_full[2]), 0);
        out_ready[2] = 1'b1;
        repeat (DEPTH + 4) tick();

        // Zero-length block, then cfg during RUN is ignored.
        tick(); issue_cfg(3, 0);
        tick(); tick();
        chk("s5_zero_block_done", done_cnt[3], 1);
        issue_cfg(3, 2);
        tick(); issue_cfg(3, 5);
        tick(); out_ready[3] = 1'b1; issue_write(3, 8'h01);
        tick(); issue_write(3, 8'h02);
        tick(); issue_write(3, 8'h03);
        repeat (6) tick();
        chk("s5_done_cnt3", done_cnt[3], 2);
        chk("s5_err3", int'(err[3]), int'(err_on));

        // Round-robin random traffic with random back-pressure.
        out_ready = '1;
        for (int f = 0; f < FLUX; f++) begin
            base[f] = done_cnt[f];
            tick(); issue_cfg(f, 23);
        end
        for (int i = 0; i < 23; i++) begin
            for (int f = 0; f < FLUX; f++) begin
                push_pel(f, 8'($urandom_range(0, 255)));
            end
        end
        tick(); out_ready = '1;
        repeat (DEPTH + 8) tick();
        for (int f = 0; f < FLUX; f++) begin
            chk($sformatf("s3_done_cnt[%0d]", f), done_cnt[f] - base[f], 1);
            chk($sformatf("s3_drained[%0d]", f), int'(out_valid[f]), 0);
        end

        // Reset in the middle of a running block.
        tick(); out_ready = '0; issue_cfg(0, 10);
        for (int i = 0; i < 7; i++) begin
            tick(); issue_write(0, 8'(8'hA0 + i));
        end
        tick(); tick();
        chk("s6_pre_rst_valid0", int'(out_valid[0]), 1);
        base[0] = done_cnt[0];
        #2;
        rst = 1'b1;
        #1;
        chk("s6_rst_out_valid", int'(out_valid), 0);
        chk("s6_rst_in_full", int'(in_full), 0);
        chk("s6_rst_out_data", int'(out_data), 0);
        chk("s6_rst_blk_done", int'(blk_done), 0);
        chk("s6_rst_err", int'(err), 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = '1;
        repeat (12) tick();
        chk("s6_no_done_after_rst", done_cnt[0], base[0]);
        chk("s6_empty_after_rst", int'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
